// File: rtl/absolute_value.sv
// Streaming two's-complement absolute-value stage: one registered cycle of latency,
// valid strobe aligned with the magnitude, optional saturation of the most-negative code.
module absolute_value #(
    parameter int DATA_WIDTH = 16,
    parameter int SATURATE   = 1
) (
    input  logic                  iclk,
    input  logic                  irst,
    input  logic                  ivalid,
    input  logic [DATA_WIDTH-1:0] idata,
    output logic                  ovalid,
    output logic [DATA_WIDTH-1:0] odata,
    output logic                  osat
);

    localparam logic [DATA_WIDTH-1:0] MOST_NEG = {1'b1, {(DATA_WIDTH-1){1'b0}}};
    localparam logic [DATA_WIDTH-1:0] MAX_POS  = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    localparam logic [DATA_WIDTH-1:0] ONE      = {{(DATA_WIDTH-1){1'b0}}, 1'b1};
    localparam bit                    SAT_EN   = (SATURATE != 0);

    logic                  valid_q;
    logic [DATA_WIDTH-1:0] data_q;
    logic [DATA_WIDTH-1:0] data_d;
    logic                  sat_q;
    logic                  sat_d;
    logic                  is_neg;
    logic                  is_min;
    logic [DATA_WIDTH-1:0] negated;

    // Without saturation the most-negative code negates onto itself (wrap).
    always_comb begin
        is_neg  = idata[DATA_WIDTH-1];
        is_min  = (idata == MOST_NEG);
        negated = (~idata) + ONE;
        sat_d   = 1'b0;
        data_d  = idata;
        if (is_neg) begin
            if (is_min && SAT_EN) begin
                data_d = MAX_POS;
                sat_d  = 1'b1;
            end else begin
                data_d = negated;
            end
        end
    end

    // Data and flag hold on idle cycles so downstream sees no toggling.
    always_ff @(posedge iclk or posedge irst) begin
        if (irst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            sat_q   <= 1'b0;
        end else begin
            valid_q <= ivalid;
            if (ivalid) begin
                data_q <= data_d;
                sat_q  <= sat_d;
            end
        end
    end

    assign ovalid = valid_q;
    assign odata  = data_q;
    assign osat   = sat_q;

endmodule

// File: tb/tb_absolute_value.sv
// Self-checking bench for absolute_value: one instance per SATURATE setting, shared stimulus.
module tb_absolute_value;

  logic        clk;
  logic        rst;
  logic        ivalid;
  logic [15:0] idata;
  logic        ovalid1, osat1, ovalid0, osat0;
  logic [15:0] odata1, odata0;

  int n_tests = 0;
  int n_fail  = 0;

  // model state: last delivered result per instance (outputs hold when idle)
  logic [15:0] m_d1, m_d0;
  logic        m_s1, m_s0;

  typedef struct {
    logic        v;
    logic [15:0] d;
    logic        ev;
    logic [15:0] ed1;
    logic        es1;
    logic [15:0] ed0;
    logic        es0;
  } vec_t;

  vec_t vecs[10];

  absolute_value #(.DATA_WIDTH(16), .SATURATE(1)) dut_sat (
    .iclk(clk), .irst(rst), .ivalid(ivalid), .idata(idata),
    .ovalid(ovalid1), .odata(odata1), .osat(osat1)
  );

  absolute_value #(.DATA_WIDTH(16), .SATURATE(0)) dut_wrap (
    .iclk(clk), .irst(rst), .ivalid(ivalid), .idata(idata),
    .ovalid(ovalid0), .odata(odata0), .osat(osat0)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // drive at negedge, sample 1ns after the capturing posedge
  task automatic step(input logic v, input logic [15:0] d);
    @(negedge clk);
    ivalid = v;
    idata  = d;
    @(posedge clk);
    #1;
  endtask

  // reference: signed magnitude via plain integer arithmetic
  function automatic logic [16:0] ref_abs(input logic [15:0] x, input bit sat);
    int a;
    a = int'($signed(x));
    if (a < 0) a = -a;
    if (a > 32767) return sat ? {1'b1, 16'h7FFF} : {1'b0, 16'h8000};
    return {1'b0, a[15:0]};
  endfunction

  task automatic check_all(input string tag, input logic ev);
    chk({tag, ".ovalid_sat"}, {31'd0, ovalid1}, {31'd0, ev});
    chk({tag, ".odata_sat"},  {16'd0, odata1},  {16'd0, m_d1});
    chk({tag, ".osat_sat"},   {31'd0, osat1},   {31'd0, m_s1});
    chk({tag, ".ovalid_wrap"},{31'd0, ovalid0}, {31'd0, ev});
    chk({tag, ".odata_wrap"}, {16'd0, odata0},  {16'd0, m_d0});
    chk({tag, ".osat_wrap"},  {31'd0, osat0},   {31'd0, m_s0});
  endtask

  initial begin
    logic [16:0] r;
    logic [15:0] d;
    logic        v;

    vecs[0] = '{1'b1, 16'h0003, 1'b1, 16'h0003, 1'b0, 16'h0003, 1'b0};
    vecs[1] = '{1'b0, 16'h1234, 1'b0, 16'h0003, 1'b0, 16'h0003, 1'b0};
    vecs[2] = '{1'b1, 16'hFFFF, 1'b1, 16'h0001, 1'b0, 16'h0001, 1'b0};
    vecs[3] = '{1'b1, 16'h8001, 1'b1, 16'h7FFF, 1'b0, 16'h7FFF, 1'b0};
    vecs[4] = '{1'b1, 16'h7FFF, 1'b1, 16'h7FFF, 1'b0, 16'h7FFF, 1'b0};
    vecs[5] = '{1'b1, 16'h0000, 1'b1, 16'h0000, 1'b0, 16'h0000, 1'b0};
    vecs[6] = '{1'b1, 16'h8000, 1'b1, 16'h7FFF, 1'b1, 16'h8000, 1'b0};
    vecs[7] = '{1'b0, 16'hFFFF, 1'b0, 16'h7FFF, 1'b1, 16'h8000, 1'b0};
    vecs[8] = '{1'b1, 16'hFF85, 1'b1, 16'h007B, 1'b0, 16'h007B, 1'b0};
    vecs[9] = '{1'b1, 16'h1234, 1'b1, 16'h1234, 1'b0, 16'h1234, 1'b0};

    // reset held two cycles
    rst = 1'b1;
    ivalid = 1'b0;
    idata = 16'h0000;
    m_d1 = 16'h0; m_s1 = 1'b0; m_d0 = 16'h0; m_s0 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_all("reset", 1'b0);
    @(negedge clk);
    rst = 1'b0;

    // directed table
    for (int i = 0; i < 10; i++) begin
      step(vecs[i].v, vecs[i].d);
      m_d1 = vecs[i].ed1; m_s1 = vecs[i].es1;
      m_d0 = vecs[i].ed0; m_s0 = vecs[i].es0;
      check_all($sformatf("vec%0d", i), vecs[i].ev);
    end

    // reset asserted mid-cycle right after a valid capture
    step(1'b1, 16'hF000);
    m_d1 = 16'h1000; m_s1 = 1'b0; m_d0 = 16'h1000; m_s0 = 1'b0;
    check_all("pre_rst", 1'b1);
    ivalid = 1'b0;
    #1;
    rst = 1'b1;
    #1;
    m_d1 = 16'h0; m_s1 = 1'b0; m_d0 = 16'h0; m_s0 = 1'b0;
    check_all("async_rst", 1'b0);
    @(negedge clk);
    rst = 1'b0;
    step(1'b0, 16'h4321);
    check_all("post_rst", 1'b0);
    step(1'b0, 16'h8000);
    check_all("post_rst2", 1'b0);

    // randomized stream with corner-biased data
    for (int i = 0; i < 400; i++) begin
      v = ($urandom_range(0, 3) != 0);
      case ($urandom_range(0, 7))
        0: d = 16'h8000;
        1: d = 16'hFFFF;
        2: d = 16'h7FFF;
        3: d = 16'h0000;
        4: d = 16'h8001;
        default: d = 16'($urandom);
      endcase
      step(v, d);
      if (v) begin
        r = ref_abs(d, 1'b1);
        m_d1 = r[15:0]; m_s1 = r[16];
        r = ref_abs(d, 1'b0);
        m_d0 = r[15:0]; m_s0 = r[16];
      end
      check_all($sformatf("rand%0d", i), v);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
